// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the CPU, debug-panel and memory-side signals around mem_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_bus_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_wait;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;
    logic          owner;
    logic          proto_err;
`ifdef DBG_LOCK_EN
    logic          dbg_lock;
`endif

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata
`ifdef DBG_LOCK_EN
        , input dbg_lock
`endif
        , output cpu_rdata, cpu_wait, dbg_rdata, dbg_ack,
        output mem_addr, mem_wdata, mem_rd, mem_wr, owner, proto_err
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata
`ifdef DBG_LOCK_EN
        , output dbg_lock
`endif
        , input cpu_rdata, cpu_wait, dbg_rdata, dbg_ack,
        input mem_addr, mem_wdata, mem_rd, mem_wr, owner, proto_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between CPU and debug panel: IDLE, WAIT_CYC+1 strobe cycles, DONE; cpu_wait stalls the CPU.
// Optional DBG_LOCK_EN adds dbg_lock so the panel can keep the bus for bulk loads.
module mem_bus_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          perr_q, perr_d;
    logic          creq_q, cwait_q;
    logic          cpu_req, cpu_wait, grant_dbg, lock;

    assign cpu_req = bus.cpu_rd | bus.cpu_wr;
`ifdef DBG_LOCK_EN
    assign lock = bus.dbg_lock;
`else
    assign lock = 1'b0;
`endif

    // Round-robin: on contention the requester that did not go last wins.
    assign grant_dbg = bus.dbg_req & (~cpu_req | lock | ~last_q);
    assign cpu_wait  = cpu_req & ~((state_q == DONE) & ~owner_q);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        perr_d      = perr_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_rd & bus.cpu_wr) perr_d = 1'b1;
                if (cpu_req | bus.dbg_req) begin
                    owner_d = grant_dbg;
                    if (grant_dbg) begin
                        addr_d  = bus.dbg_addr;
                        wdata_d = bus.dbg_wdata;
                        we_d    = bus.dbg_we;
                    end else begin
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                        we_d    = bus.cpu_wr;
                    end
                    wcnt_d  = 4'(WAIT_CYC);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q) dbg_rdata_d = bus.mem_rdata;
                        else         cpu_rdata_d = bus.mem_rdata;
                    end
                end
            end
            DONE: begin
                if (!(lock & owner_q)) last_d = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A stalled CPU abandoning its request outside its own access is a protocol breach.
        if (creq_q & cwait_q & ~cpu_req & ~((state_q != IDLE) & ~owner_q)) perr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= 4'd0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            perr_q      <= 1'b0;
            creq_q      <= 1'b0;
            cwait_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            perr_q      <= perr_d;
            creq_q      <= cpu_req;
            cwait_q     <= cpu_wait;
        end
    end

    assign bus.cpu_wait  = cpu_wait;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.dbg_ack   = (state_q == DONE) & owner_q;
    assign bus.mem_rd    = (state_q == ACCESS) & ~we_q;
    assign bus.mem_wr    = (state_q == ACCESS) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.owner     = owner_q;
    assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized CPU/debug traffic against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int W  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_pat(input int a);
        logic [15:0] av;
        av = 16'(a);
        return (av == 16'h0010) ? 8'h5A : (av[7:0] ^ av[15:8] ^ 8'hA5);
    endfunction

    // Memory attached to the bus.
    logic [7:0] bmem [0:65535];
    assign bus.mem_rdata = bmem[bus.mem_addr];
    initial begin
        for (int i = 0; i < 65536; i++) bmem[i] = init_pat(i);
        forever begin
            @(posedge clk);
            if (bus.mem_wr) bmem[bus.mem_addr] = bus.mem_wdata;
        end
    end

    // Transaction-level reference: m_t counts cycles left in the current transaction
    // (W+1 strobe cycles then one completion cycle), 0 meaning the bus is free.
    int          m_t;
    logic        m_owner, m_last, m_we, m_perr, m_prev_req, m_prev_wait, prev_strb;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_crd, m_drd;
    logic [7:0]  shadow [0:65535];
    int          dgr[$];

    task automatic model_reset();
        m_t = 0; m_owner = 0; m_last = 1; m_we = 0; m_perr = 0;
        m_prev_req = 0; m_prev_wait = 0; prev_strb = 0;
        m_addr = 0; m_wdata = 0; m_crd = 0; m_drd = 0;
    endtask

    initial begin
        logic creq, ewait, lk, pick_dbg, nperr;
        for (int i = 0; i < 65536; i++) shadow[i] = init_pat(i);
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
            end else begin
`ifdef DBG_LOCK_EN
                lk = bus.dbg_lock;
`else
                lk = 1'b0;
`endif
                creq  = bus.cpu_rd | bus.cpu_wr;
                ewait = creq && !(m_t == 1 && !m_owner);
                chk("mem_rd",    32'(bus.mem_rd),    32'(m_t >= 2 && !m_we));
                chk("mem_wr",    32'(bus.mem_wr),    32'(m_t >= 2 && m_we));
                chk("cpu_wait",  32'(bus.cpu_wait),  32'(ewait));
                chk("dbg_ack",   32'(bus.dbg_ack),   32'(m_t == 1 && m_owner));
                chk("owner",     32'(bus.owner),     32'(m_owner));
                chk("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
                chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_crd));
                chk("dbg_rdata", 32'(bus.dbg_rdata), 32'(m_drd));
                chk("proto_err", 32'(bus.proto_err), 32'(m_perr));
                if ((bus.mem_rd || bus.mem_wr) && !prev_strb) dgr.push_back(int'(bus.owner));
                prev_strb = bus.mem_rd | bus.mem_wr;

                nperr = m_perr;
                if (m_prev_req && m_prev_wait && !creq && !(m_t > 0 && !m_owner)) nperr = 1;
                if (m_t == 0) begin
                    if (bus.cpu_rd && bus.cpu_wr) nperr = 1;
                    if (creq || bus.dbg_req) begin
                        pick_dbg = bus.dbg_req && (!creq || lk || m_last == 1'b0);
                        m_owner  = pick_dbg;
                        m_addr   = pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
                        m_wdata  = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                        m_we     = pick_dbg ? bus.dbg_we    : bus.cpu_wr;
                        m_t      = W + 2;
                    end
                end else if (m_t == 1) begin
                    if (!(lk && m_owner)) m_last = m_owner;
                    m_t = 0;
                end else begin
                    if (m_t == 2) begin
                        if (m_we)         shadow[m_addr] = m_wdata;
                        else if (m_owner) m_drd = shadow[m_addr];
                        else              m_crd = shadow[m_addr];
                    end
                    m_t--;
                end
                m_prev_req  = creq;
                m_prev_wait = ewait;
                m_perr      = nperr;
            end
        end
    end

    // Both drivers are entered and return at posedge+1.
    task automatic cpu_txn(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d,
                           output int nwait, output int nstrb);
        logic got;
        got = 0; nwait = 0; nstrb = 0;
        bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_rd || bus.mem_wr) nstrb++;
            if (!bus.cpu_wait) got = 1;
            else nwait++;
        end
        checks++;
        if (!got) begin fails++; $display("FAIL cpu_wait_timeout actual=stalled required=released"); end
        @(posedge clk); #1;
        bus.cpu_rd = 0; bus.cpu_wr = 0;
    endtask

    task automatic dbg_txn(input logic we, input logic [15:0] a, input logic [7:0] d, output int nstrb);
        logic got;
        got = 0; nstrb = 0;
        bus.dbg_req = 1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((bus.mem_rd || bus.mem_wr) && bus.owner && bus.mem_wr == we &&
                bus.mem_addr == a && (!we || bus.mem_wdata == d)) nstrb++;
            if (bus.dbg_ack) got = 1;
        end
        checks++;
        if (!got) begin fails++; $display("FAIL dbg_ack_timeout actual=no_ack required=ack"); end
        @(posedge clk); #1;
        bus.dbg_req = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
`ifdef DBG_LOCK_EN
        bus.dbg_lock = 0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_rd"},    32'(bus.mem_rd),    0);
        chk({tag, "_mem_wr"},    32'(bus.mem_wr),    0);
        chk({tag, "_dbg_ack"},   32'(bus.dbg_ack),   0);
        chk({tag, "_owner"},     32'(bus.owner),     0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr),  0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        chk({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 0);
        chk({tag, "_dbg_rdata"}, 32'(bus.dbg_rdata), 0);
        chk({tag, "_proto_err"}, 32'(bus.proto_err), 0);
        chk({tag, "_cpu_wait"},  32'(bus.cpu_wait),  0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nw, ns, acks, hit;
        int exp3[4];
        int exp6[5];
        exp3 = '{0, 1, 0, 1};
        exp6 = '{1, 1, 1, 1, 0};

        do_reset();
        check_all_zero("reset");

        // CPU read with no contention.
        cpu_txn(1, 0, 16'h0010, 8'h00, nw, ns);
        chk("t1_rd_cycles", 32'(ns), 2);
        chk("t1_wait_cycles", 32'(nw), 3);
        chk("t1_cpu_rdata", 32'(bus.cpu_rdata), 32'h5A);

        // Debug write: strobe width, address/data, single-cycle ack.
        dbg_txn(1, 16'h1234, 8'hC3, ns);
        chk("t2_wr_cycles", 32'(ns), 2);
        chk("t2_owner", 32'(bus.owner), 1);
        acks = 0;
        repeat (3) begin @(negedge clk); if (bus.dbg_ack) acks++; end
        chk("t2_ack_extra", 32'(acks), 0);
        chk("t2_mem_1234", 32'(bmem[16'h1234]), 32'hC3);

        // Simultaneous requests straight after reset alternate starting with the CPU.
        do_reset();
        dgr.delete();
        fork
            begin int a, b; repeat (2) cpu_txn(1, 0, 16'h0003, 8'h00, a, b); end
            begin int c; repeat (2) dbg_txn(0, 16'h0004, 8'h00, c); end
        join
        chk("t3_grant_count", 32'(dgr.size()), 4);
        for (int i = 0; i < 4 && i < dgr.size(); i++) chk("t3_grant_order", 32'(dgr[i]), 32'(exp3[i]));

        // Reset in the middle of a debug read.
        do_reset();
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 16'h0040;
        hit = 0;
        for (int i = 0; i < 20 && hit == 0; i++) begin @(negedge clk); if (bus.mem_rd) hit = 1; end
        chk("t4_reached_access", 32'(hit), 1);
        #2 rst = 1;
        #1 check_all_zero("t4_midreset");
        bus.dbg_req = 0;
        acks = 0;
        repeat (2) begin @(negedge clk); if (bus.dbg_ack) acks++; end
        @(posedge clk); #2 rst = 0;
        repeat (2) begin @(negedge clk); if (bus.dbg_ack) acks++; end
        chk("t4_no_ack", 32'(acks), 0);
        @(posedge clk); #1;
        cpu_txn(1, 0, 16'h0010, 8'h00, nw, ns);
        chk("t4_clean_wait", 32'(nw), 3);
        chk("t4_clean_rdata", 32'(bus.cpu_rdata), 32'h5A);

        // Read and write strobed together: performed as a write, sticky error.
        do_reset();
        cpu_txn(1, 1, 16'h0002, 8'h77, nw, ns);
        chk("t5_perr", 32'(bus.proto_err), 1);
        chk("t5_mem_0002", 32'(bmem[16'h0002]), 32'h77);
        cpu_txn(1, 0, 16'h0002, 8'h00, nw, ns);
        chk("t5_readback", 32'(bus.cpu_rdata), 32'h77);
        dbg_txn(1, 16'h0005, 8'h11, ns);
        dbg_txn(0, 16'h0005, 8'h00, ns);
        chk("t5_dbg_readback", 32'(bus.dbg_rdata), 32'h11);
        chk("t5_perr_sticky", 32'(bus.proto_err), 1);
        do_reset();
        chk("t5_perr_cleared", 32'(bus.proto_err), 0);

        // CPU abandoning a stalled request while debug owns the bus.
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 16'h0050; bus.dbg_wdata = 8'h3C;
        hit = 0;
        for (int i = 0; i < 20 && hit == 0; i++) begin @(negedge clk); if (bus.mem_wr) hit = 1; end
        @(posedge clk); #1 bus.cpu_rd = 1; bus.cpu_addr = 16'h0001;
        @(posedge clk); #1 bus.cpu_rd = 0;
        hit = 0;
        for (int i = 0; i < 20 && hit == 0; i++) begin @(negedge clk); if (bus.dbg_ack) hit = 1; end
        @(posedge clk); #1 bus.dbg_req = 0;
        chk("t5b_abandon_perr", 32'(bus.proto_err), 1);

`ifdef DBG_LOCK_EN
        // Locked bulk load keeps the CPU stalled until the lock drops.
        do_reset();
        dgr.delete();
        bus.dbg_lock = 1;
        fork
            begin cpu_txn(1, 0, 16'h0010, 8'h00, nw, ns); end
            begin
                int c;
                for (int i = 0; i < 4; i++) dbg_txn(1, 16'(16'h0100 + i), 8'(8'hE0 + i), c);
                bus.dbg_lock = 0;
            end
        join
        chk("t6_cpu_wait_cycles", 32'(nw), 32'(4 * (W + 3) + W + 2));
        chk("t6_grant_count", 32'(dgr.size()), 5);
        for (int i = 0; i < 5 && i < dgr.size(); i++) chk("t6_grant_order", 32'(dgr[i]), 32'(exp6[i]));
`endif

        // Randomized concurrent traffic against the model.
        do_reset();
        fork
            begin
                int a, b, gap, op;
                for (int i = 0; i < 40; i++) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin @(posedge clk); #1; end
                    op = $urandom_range(0, 1);
                    cpu_txn(op == 0, op == 1, 16'($urandom_range(0, 7)), 8'($urandom), a, b);
                end
            end
            begin
                int c, gap;
                for (int i = 0; i < 40; i++) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin @(posedge clk); #1; end
                    dbg_txn(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 8'($urandom), c);
                end
            end
        join
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
